uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter (8N1; optional even parity). Pairs with the AES link's UART receiver.
//  Serialises bytes from the AES output datapath onto the TX line.
//  Bit timing: 16 ticks per bit, TICK_DIV clocks per tick, so the TX and RX bit periods match exactly.
//  Byte intake is a valid/ready handshake from the upstream ciphertext byte stream.
// PARAMETERS
//  TICK_DIV    27  clocks per oversample tick (50 MHz / (115200*16))
//  OVERSAMPLE  16  ticks per bit; bit period = TICK_DIV*OVERSAMPLE = 432 clk
// PORTS
//  clk       in   1  system clock, 50 MHz
//  rst_n     in   1  asynchronous active-low reset
//  data_in   in   8  byte to send; sampled only on accept
//  valid_in  in   1  data_in valid
//  ready     out  1  high only in IDLE; accept = valid_in & ready
//  tx        out  1  serial line, idle high
//  busy      out  1  frame in progress (any state except IDLE)
//  done      out  1  one-clk pulse when the stop bit completes
// BEHAVIOUR
//  - One clock domain: clk. Reset is asynchronous, active-low (rst_n).
//  - Reset values: tx=1, ready=1, busy=0, done=0.
//  - All internal counters and the shift register clear on reset.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE
//    - tx=1, ready=1.
//    - On accept: latch data_in into the shift register, clear the tick and clock counters, go to START.
//    - ready=0 from the next clock.
//  - Latency: tx falls exactly 1 clk after the accept edge.
//  - START: tx=0 for one bit period.
//  - DATA
//    - Drive shift[0], LSB first.
//    - Shift right at the end of each bit period.
//    - bit_index counts 0..7; leave after bit 7.
//  - PARITY (macro only): tx = ^byte for one bit period (even parity).
//  - STOP: tx=1 for one bit period.
//  - End of STOP, in the same clk:
//    - go to IDLE and pulse done.
//    - ready=1 on the following clk.
//  - Bit period: exactly TICK_DIV*OVERSAMPLE clocks.
//    - Clock counter wraps at TICK_DIV-1 and increments the tick counter.
//    - Bit boundary = tick counter == OVERSAMPLE-1 AND clock counter wrap.
//  - Frame length: 10 bit periods (4320 clk); 11 bit periods with parity.
//  - Back-to-back: next byte may be accepted the clk after ready rises.
//    - Minimum idle between frames is 2 clk of tx=1.
//  - valid_in while ready=0: ignored, byte not captured. Upstream must hold valid_in.
//  - data_in changing mid-frame: no effect.
//  - Reset mid-frame: immediate abort; tx=1 asynchronously; the next frame starts clean.
//  - tx is driven from a register (glitch-free).
// CONFIGURATION
//  UART_TX_PARITY_EN
//    - Defined: PARITY state inserted between DATA and STOP; even parity; 11-bit frame.
//    - Undefined: the PARITY state and its logic are absent; 8N1 10-bit frame.
//  The receiver must be built with the matching setting.
// STRUCTURE
//  Shared package uart_pkg:
//    - uart_state_e enum: IDLE, START, DATA, PARITY, STOP.
//    - Default constants CLK_HZ, BAUD, TICK_DIV, OVERSAMPLE.
//    - DATA_BITS=8.
//  Sub-module uart_baud_tick:
//    - Tick generator, TICK_DIV clocks per tick.
//    - Ports: clk, rst_n, clr, tick.
//    - Also usable by the receiver.
//  FSM and shift register stay in uart_tx.
// TESTING
//  - Reset: rst_n=0 for 5 clk -> tx=1, ready=1, busy=0, done=0 throughout.
//  - Send 0x55 -> tx: 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop).
//    - Each level lasts 432 clk.
//    - done pulses once at clk 4320 after accept.
//  - Back-to-back 0xA5 then 0x3C (valid_in held high)
//    - Second start edge 4322 clk after the first.
//    - Loopback into the receiver yields 0xA5, 0x3C.
//  - valid_in pulsed with 0xFF during the frame for 0x12 -> only 0x12 transmitted; 0xFF dropped.
//  - Reset asserted at clk 1000 of a frame
//    - tx=1 immediately.
//    - A new send of 0x81 after release is received correctly.
//  - UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
//    - Frame length 4752 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, default bit timing and data width.
package uart_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned BAUD       = 115_200;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable via clr.
// tick is registered and high in the same cycle the internal counter sits at DIV-1.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next clock-counter value: restart on clr, wrap at DIV-1
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == CW'(DIV - 1))) begin
            cnt_d = '0;
        end
    end

    // Counter and tick register; tick marks the wrap cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == CW'(DIV - 1));
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 stop bit, 16 ticks per bit.
// Build option UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// tx/ready/busy/done are registered; tx follows the frame state one clock later,
// so the line falls one clock after the accepting edge.
module uart_tx
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned TCW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [TCW-1:0]       tick_cnt_q;
    logic [BIW-1:0]       bit_idx_q;
    logic                 tick;
    logic                 accept;
    logic                 bit_end;
    logic                 last_bit;
    logic                 tx_d;
    logic                 ready_d;
    logic                 busy_d;
    logic                 done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign accept   = valid_in & ready;
    assign bit_end  = tick & (tick_cnt_q == TCW'(OVERSAMPLE - 1));
    assign last_bit = (bit_idx_q == BIW'(DATA_BITS - 1));

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d = state_q;
        tx_d    = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = ~accept;
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Shift register, tick counter and bit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
        end else if (accept) begin
            shift_q    <= data_in;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
        end else begin
            if (tick) begin
                tick_cnt_q <= (tick_cnt_q == TCW'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + TCW'(1);
            end
            if (bit_end && (state_q == DATA)) begin
                shift_q   <= shift_q >> 1;
                bit_idx_q <= last_bit ? '0 : bit_idx_q + BIW'(1);
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the accepted byte, captured before shifting destroys it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^data_in;
        end
    end
`endif

    // Registered outputs; reset leaves the line idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tx    <= tx_d;
            ready <= ready_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: stimulus pushes hand-computed frames into a scoreboard,
// a line monitor decodes tx and compares every bit period, byte and done pulse.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned BP = TICK_DIV * OVERSAMPLE;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    // frame bit 0 = start, then data LSB first, [parity], stop
    typedef struct packed {
        logic [7:0]    data;
        logic [NB-1:0] frame;
    } exp_t;

`ifdef UART_TX_PARITY_EN
    localparam exp_t V55 = '{8'h55, 11'b1_0_01010101_0};
    localparam exp_t VA5 = '{8'hA5, 11'b1_0_10100101_0};
    localparam exp_t V3C = '{8'h3C, 11'b1_0_00111100_0};
    localparam exp_t V12 = '{8'h12, 11'b1_0_00010010_0};
    localparam exp_t V00 = '{8'h00, 11'b1_0_00000000_0};
    localparam exp_t V81 = '{8'h81, 11'b1_0_10000001_0};
    localparam exp_t V07 = '{8'h07, 11'b1_1_00000111_0};
    localparam exp_t V03 = '{8'h03, 11'b1_0_00000011_0};
`else
    localparam exp_t V55 = '{8'h55, 10'b1_01010101_0};
    localparam exp_t VA5 = '{8'hA5, 10'b1_10100101_0};
    localparam exp_t V3C = '{8'h3C, 10'b1_00111100_0};
    localparam exp_t V12 = '{8'h12, 10'b1_00010010_0};
    localparam exp_t V00 = '{8'h00, 10'b1_00000000_0};
    localparam exp_t V81 = '{8'h81, 10'b1_10000001_0};
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int          checks   = 0;
    int          fails    = 0;
    int unsigned cyc      = 0;
    int unsigned last_acc = 0;
    bit          mon_busy = 1'b0;
    exp_t        exp_q[$];
    int unsigned acc_q[$];

    uart_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present a byte and wait (bounded) for the accepting edge
    task automatic send(input exp_t e, input bit hold);
        int unsigned n;
        n = 0;
        @(negedge clk);
        data_in  = e.data;
        valid_in = 1'b1;
        while (!ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: byte 0x%02h never accepted", e.data);
            valid_in = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            last_acc = cyc;
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            if (!hold) valid_in = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            fails++;
            $display("FAIL wait_idle_timeout: %0d bytes outstanding", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // Called at the first negedge with tx low; samples every clock of the frame
    task automatic decode_frame();
        exp_t          e;
        int unsigned   acc;
        int unsigned   start_cyc;
        logic [NB-1:0] bad;
        logic [7:0]    rx;
        logic          done_ok;
        bit            aborted;
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_frame: start bit at cycle %0d with no byte outstanding", cyc);
            return;
        end
        e        = exp_q.pop_front();
        acc      = acc_q.pop_front();
        mon_busy = 1'b1;
        bad      = '0;
        rx       = '0;
        done_ok  = 1'b1;
        aborted  = 1'b0;
        for (int unsigned k = 0; k < NB * BP; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
                aborted = 1'b1;
                break;
            end
            if (tx !== e.frame[k / BP]) bad[k / BP] = 1'b1;
            if ((k % BP == BP / 2) && (k / BP >= 1) && (k / BP <= 8)) rx[k / BP - 1] = tx;
            if (done !== (k == NB * BP - 1)) done_ok = 1'b0;
        end
        mon_busy = 1'b0;
        if (aborted) return;
        check($sformatf("tx_latency_%02h", e.data), 32'(start_cyc - acc), 32'd1);
        for (int unsigned b = 0; b < NB; b++) begin
            check($sformatf("bit%0d_level_%02h", b, e.data), 32'(bad[b]), 32'd0);
        end
        check("rx_byte", 32'(rx), 32'(e.data));
        check($sformatf("done_pulse_%02h", e.data), 32'(done_ok), 32'd1);
    endtask

    // Line monitor: detect start edges and decode frames
    initial begin : monitor
        logic prev_tx;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tx = 1'b1;
            end else begin
                if (prev_tx && !tx) decode_frame();
                prev_tx = tx;
            end
        end
    end

    // Stimulus
    initial begin : stim
        int unsigned a1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs", 32'({tx, ready, busy, done}), 32'b1100);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'({tx, ready, busy, done}), 32'b1100);

        send(V55, 1'b0);
        @(negedge clk);
        check("ready_low_after_accept", 32'({ready, busy}), 32'b01);
        wait_idle();

        send(VA5, 1'b1);
        a1 = last_acc;
        send(V3C, 1'b0);
        check("b2b_accept_spacing", 32'(last_acc - a1), 32'(NB * BP + 2));
        wait_idle();

        send(V12, 1'b0);
        repeat (500) @(negedge clk);
        data_in  = 8'hFF;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        wait_idle();

        send(V00, 1'b0);
        repeat (999) @(negedge clk);
        check("tx_low_before_reset", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({tx, ready, busy, done}), 32'b1100);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("aborted_frame_dropped", 32'(exp_q.size()), 32'd0);

        send(V81, 1'b0);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        send(V07, 1'b0);
        wait_idle();
        send(V03, 1'b0);
        wait_idle();
`endif

        repeat (200) @(negedge clk);
        check("no_outstanding_bytes", 32'(exp_q.size()), 32'd0);
        check("final_idle_outputs", 32'({tx, ready, busy, done}), 32'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
